// File: rtl/axi_rd_burst_seq.sv
// -----------------------------------------------------------------------------
// axi_rd_burst_seq
//
// Read-burst sequencer. Sits between the AXI slave arlen FIFO and the memory
// read-command port. For every arlen entry it pops one FIFO word and issues
// arlen+1 single-beat read commands. Each command carries its beat index and a
// last flag so the R-channel logic downstream can drive rlast.
//
// Handshake: a command beat transfers on a rising clk edge where
// mem_cmd_valid && mem_cmd_ready. Once valid is raised, valid/beat/last hold
// stable until the beat is accepted; the only way valid drops early is flush.
//
// Optional feature (macro AXI_RD_SEQ_LEN_CHK_EN):
//   defined   - arlen above MAX_LEN is clamped to MAX_LEN on load and sets the
//               sticky len_err flag (cleared only by rst_n).
//   undefined - no clamp, len_err tied to 0.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   arlen_fifo_empty   FIFO empty flag
//   arlen_fifo_dout    FIFO head word, valid whenever empty=0
//   arlen_fifo_rd      pop strobe (active-high, same cycle as the load)
//   flush              synchronous abort of the current burst
//   mem_cmd_valid      read command valid
//   mem_cmd_ready      memory accepts the command
//   mem_cmd_beat       beat index within the burst, 0..len
//   mem_cmd_last       final beat of the burst
//   seq_busy           burst in progress
//   burst_done         one-cycle pulse the cycle after the last beat is accepted
//   len_err            sticky length error (0 when the check is compiled out)
//   dbg_state          FSM state (0=IDLE, 1=BURST)
// -----------------------------------------------------------------------------
module axi_rd_burst_seq #(
  parameter int LEN_W   = 8,
  parameter int MAX_LEN = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arlen_fifo_empty,
  input  logic [LEN_W-1:0] arlen_fifo_dout,
  output logic             arlen_fifo_rd,
  input  logic             flush,
  output logic             mem_cmd_valid,
  input  logic             mem_cmd_ready,
  output logic [LEN_W-1:0] mem_cmd_beat,
  output logic             mem_cmd_last,
  output logic             seq_busy,
  output logic             burst_done,
  output logic             len_err,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_q;
  logic             done_q;

  logic             in_burst;
  logic             beat_last;
  logic             accept;
  logic             load;
  logic [LEN_W-1:0] load_len;

  assign in_burst  = (state_q == BURST);
  assign beat_last = in_burst && (beat_q == len_q);
  assign accept    = in_burst && mem_cmd_ready;

  // A new burst is loaded either from IDLE or in the very cycle the previous
  // burst's last beat is accepted, which removes the idle bubble between
  // back-to-back bursts. Flush suppresses the pop for that cycle.
  assign load = !flush && !arlen_fifo_empty && (!in_burst || (accept && beat_last));

  // Gated by rst_n so the pop strobe is also 0 while reset is held.
  assign arlen_fifo_rd = rst_n && load;

`ifdef AXI_RD_SEQ_LEN_CHK_EN
  localparam logic [LEN_W-1:0] LenCap = LEN_W'(MAX_LEN);

  logic len_over;
  logic err_q;

  assign len_over = (arlen_fifo_dout > LenCap);
  assign load_len = len_over ? LenCap : arlen_fifo_dout;

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (load && len_over) begin
      err_q <= 1'b1;
    end
  end

  assign len_err = err_q;
`else
  assign load_len = arlen_fifo_dout;
  assign len_err  = 1'b0;

  // MAX_LEN only shapes the optional clamp; keep it referenced here.
  if (MAX_LEN < 0) begin : g_max_len_neg
  end
`endif

  // Sequencer FSM. Flush wins over every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
      end else if (load) begin
        state_q <= BURST;
        len_q   <= load_len;
        beat_q  <= '0;
        // Loading while in a burst means the previous last beat just went out.
        done_q  <= in_burst;
      end else if (accept) begin
        if (beat_last) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else begin
          beat_q <= beat_q + LEN_W'(1);
        end
      end
    end
  end

  assign mem_cmd_valid = in_burst;
  assign seq_busy      = in_burst;
  assign mem_cmd_beat  = in_burst ? beat_q : '0;
  assign mem_cmd_last  = beat_last;
  assign burst_done    = done_q;
  assign dbg_state     = state_q;

endmodule
